// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared types for the nibble ALU sequencer
package alu_sequencer_pkg;

  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W:0] BCD_MAX = 5'd9;
  localparam logic [NIBBLE_W:0] BCD_ADJ5 = 5'd6;
  localparam logic [NIBBLE_W-1:0] BCD_ADJ4 = 4'd6;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_RRC = 3'd6,
    ALU_RLC = 3'd7
  } alu_op;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_READ_A = 3'd1,
    SEQ_READ_B = 3'd2,
    SEQ_EXEC   = 3'd3,
    SEQ_WRITE  = 3'd4,
    SEQ_DONE   = 3'd5
  } seq_state;

  // Unary ops only consume operand A, so the B fetch is skipped.
  function automatic logic is_unary(alu_op op);
    return (op == ALU_NOT) || (op == ALU_RRC) || (op == ALU_RLC);
  endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// rtl/alu_sequencer_alu.sv - combinational 4-bit ALU with BCD adjust
module alu_sequencer_alu
  import alu_sequencer_pkg::*;
(
  input  alu_op       i_op,
  input  logic [3:0]  i_a,
  input  logic [3:0]  i_b,
  input  logic        i_carry,
  input  logic        i_use_carry,
  input  logic        i_decimal,
  output logic [3:0]  o_result,
  output logic        o_carry,
  output logic        o_zero
);

  logic       w_cin;
  logic [4:0] w_sum;
  logic [4:0] w_diff;
  logic [4:0] w_sum_adj;

  // Carry participates in arithmetic only when requested; SUB carry means borrow.
  assign w_cin     = i_carry & i_use_carry;
  assign w_sum     = {1'b0, i_a} + {1'b0, i_b} + {4'b0, w_cin};
  assign w_diff    = {1'b0, i_a} - {1'b0, i_b} - {4'b0, w_cin};
  assign w_sum_adj = w_sum + BCD_ADJ5;

  // Result and carry per operation; logic ops pass the incoming carry through.
  always_comb begin
    o_result = 4'd0;
    o_carry  = i_carry;
    case (i_op)
      ALU_ADD: begin
        if (i_decimal && (w_sum > BCD_MAX)) begin
          o_result = w_sum_adj[3:0];
          o_carry  = 1'b1;
        end else begin
          o_result = w_sum[3:0];
          o_carry  = w_sum[4];
        end
      end
      ALU_SUB: begin
        o_carry  = w_diff[4];
        o_result = (i_decimal && w_diff[4]) ? (w_diff[3:0] - BCD_ADJ4) : w_diff[3:0];
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_NOT: o_result = ~i_a;
      ALU_RRC: begin
        o_result = {i_carry, i_a[3:1]};
        o_carry  = i_a[0];
      end
      ALU_RLC: begin
        o_result = {i_a[2:0], i_carry};
        o_carry  = i_a[3];
      end
      default: o_result = 4'd0;
    endcase
  end

  assign o_zero = (o_result == 4'd0);

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle memory-operand ALU sequencer
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  alu_op                 i_req_op,
  input  logic                  i_req_use_carry,
  input  logic [ADDR_WIDTH-1:0] i_req_addr_a,
  input  logic [ADDR_WIDTH-1:0] i_req_addr_b,
  input  logic                  i_req_b_imm,
  input  logic [3:0]            i_req_imm,
  input  logic [LEN_WIDTH-1:0]  i_req_len,
  input  logic                  i_req_writeback,
  input  logic                  i_flag_carry_in,
  input  logic                  i_flag_decimal_in,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd,
  input  logic [3:0]            i_mem_rdata,
  output logic                  o_mem_wr,
  output logic [3:0]            o_mem_wdata,
  output logic                  o_flag_carry,
  output logic                  o_flag_zero,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

  seq_state              r_state;
  alu_op                 r_op;
  logic                  r_use_carry;
  logic [ADDR_WIDTH-1:0] r_addr_a;
  logic [ADDR_WIDTH-1:0] r_addr_b;
  logic                  r_b_imm;
  logic [3:0]            r_imm;
  logic [LEN_WIDTH-1:0]  r_count;
  logic                  r_writeback;
  logic                  r_decimal;
  logic                  r_carry_acc;
  logic                  r_zero_acc;
  logic                  r_first;
  logic [3:0]            r_temp_a;
  logic [3:0]            r_result;
  logic                  r_req_ready;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_rd;
  logic                  r_mem_wr;
  logic [3:0]            r_mem_wdata;
  logic                  r_flag_carry;
  logic                  r_flag_zero;
  logic                  r_done;

  logic                  w_skip_b;
  logic [3:0]            w_temp_a;
  logic [3:0]            w_temp_b;
  logic                  w_alu_use_carry;
  logic [3:0]            w_alu_result;
  logic                  w_alu_carry;
  logic                  w_alu_zero;

  // When B is not fetched from memory, operand A arrives on rdata in EXEC.
  assign w_skip_b        = r_b_imm | is_unary(r_op);
  assign w_temp_a        = w_skip_b ? i_mem_rdata : r_temp_a;
  assign w_temp_b        = r_b_imm ? r_imm : i_mem_rdata;
  assign w_alu_use_carry = r_first ? r_use_carry : 1'b1;

  alu_sequencer_alu u_alu (
    .i_op        (r_op),
    .i_a         (w_temp_a),
    .i_b         (w_temp_b),
    .i_carry     (r_carry_acc),
    .i_use_carry (w_alu_use_carry),
    .i_decimal   (r_decimal),
    .o_result    (w_alu_result),
    .o_carry     (w_alu_carry),
    .o_zero      (w_alu_zero)
  );

  // Sequencer FSM; memory strobes are registered so they line up with the state they belong to.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= SEQ_IDLE;
      r_op         <= ALU_ADD;
      r_use_carry  <= 1'b0;
      r_addr_a     <= '0;
      r_addr_b     <= '0;
      r_b_imm      <= 1'b0;
      r_imm        <= 4'd0;
      r_count      <= '0;
      r_writeback  <= 1'b0;
      r_decimal    <= 1'b0;
      r_carry_acc  <= 1'b0;
      r_zero_acc   <= 1'b0;
      r_first      <= 1'b0;
      r_temp_a     <= 4'd0;
      r_result     <= 4'd0;
      r_req_ready  <= 1'b1;
      r_mem_addr   <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_wdata  <= 4'd0;
      r_flag_carry <= 1'b0;
      r_flag_zero  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          if (i_req_valid && r_req_ready) begin
            r_op        <= i_req_op;
            r_use_carry <= i_req_use_carry;
            r_addr_a    <= i_req_addr_a;
            r_addr_b    <= i_req_addr_b;
            r_b_imm     <= i_req_b_imm;
            r_imm       <= i_req_imm;
            r_count     <= i_req_len;
            r_writeback <= i_req_writeback;
            r_decimal   <= i_flag_decimal_in;
            r_carry_acc <= i_flag_carry_in;
            r_zero_acc  <= 1'b1;
            r_first     <= 1'b1;
            r_req_ready <= 1'b0;
            r_mem_addr  <= i_req_addr_a;
            r_mem_rd    <= 1'b1;
            r_state     <= SEQ_READ_A;
          end
        end
        SEQ_READ_A: begin
          if (w_skip_b) begin
            r_mem_rd <= 1'b0;
            r_state  <= SEQ_EXEC;
          end else begin
            r_mem_addr <= r_addr_b;
            r_mem_rd   <= 1'b1;
            r_state    <= SEQ_READ_B;
          end
        end
        SEQ_READ_B: begin
          r_temp_a <= i_mem_rdata;
          r_mem_rd <= 1'b0;
          r_state  <= SEQ_EXEC;
        end
        SEQ_EXEC: begin
          r_result    <= w_alu_result;
          r_carry_acc <= w_alu_carry;
          r_zero_acc  <= r_zero_acc & w_alu_zero;
          r_first     <= 1'b0;
          if (r_writeback) begin
            r_mem_addr  <= r_addr_a;
            r_mem_wr    <= 1'b1;
            r_mem_wdata <= w_alu_result;
          end
          r_state <= SEQ_WRITE;
        end
        SEQ_WRITE: begin
          r_mem_wr <= 1'b0;
          if (r_count != '0) begin
            r_addr_a   <= r_addr_a + ADDR_ONE;
            r_addr_b   <= r_addr_b + ADDR_ONE;
            r_count    <= r_count - LEN_ONE;
            r_mem_addr <= r_addr_a + ADDR_ONE;
            r_mem_rd   <= 1'b1;
            r_state    <= SEQ_READ_A;
          end else begin
            r_done       <= 1'b1;
            r_flag_carry <= r_carry_acc;
            r_flag_zero  <= r_zero_acc;
            r_state      <= SEQ_DONE;
          end
        end
        SEQ_DONE: begin
          r_done      <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= SEQ_IDLE;
        end
        default: r_state <= SEQ_IDLE;
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_rd     = r_mem_rd;
  assign o_mem_wr     = r_mem_wr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_flag_carry = r_flag_carry;
  assign o_flag_zero  = r_flag_zero;
  assign o_done       = r_done;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle execution engine that drives the combinational ALU for memory-operand arithmetic and logic instructions.
- Accepts an operation request over a valid/ready handshake.
- Fetches operand nibbles from nibble memory and presents them to the ALU.
- Writes the result back and maintains the carry and zero flags.
- Supports multi-nibble chained operations (multi-digit BCD add/sub) with automatic carry propagation.

Parameters:
ADDR_WIDTH, 12, nibble memory address width
LEN_WIDTH, 3, width of the nibble-count field (operates on up to 2^LEN_WIDTH nibbles)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_op  in  alu_op  operation to perform
req_use_carry  in  1  include carry-in on first nibble (ADD/SUB only)
req_addr_a  in  ADDR_WIDTH  operand A / destination address (least significant nibble)
req_addr_b  in  ADDR_WIDTH  operand B address
req_b_imm  in  1  B taken from req_imm, not memory
req_imm  in  4  immediate B nibble
req_len  in  LEN_WIDTH  nibble count minus one
req_writeback  in  1  write result to A (0 for CP-style compare)
flag_carry_in  in  1  CPU carry flag, sampled at accept
flag_decimal_in  in  1  CPU decimal flag, sampled at accept
mem_addr  out  ADDR_WIDTH  memory address
mem_rd  out  1  read strobe; data valid on mem_rdata the following cycle
mem_rdata  in  4  read data
mem_wr  out  1  write strobe
mem_wdata  out  4  write data
flag_carry  out  1  resulting carry flag
flag_zero  out  1  resulting zero flag
done  out  1  one-cycle pulse at completion

Behaviour:
- Reset values:
  - State IDLE; req_ready=1.
  - mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - flag_carry=0, flag_zero=0, done=0; all internal registers 0.
- Accept: on req_valid && req_ready, latch all req_* fields plus flag_carry_in and flag_decimal_in. Set carry_acc = flag_carry_in, zero_acc = 1. Go to READ_A.
- READ_A: mem_addr=addr_a, mem_rd=1. Next state:
  - unary op (NOT/RRC/RLC) or req_b_imm: EXEC
  - otherwise: READ_B
- READ_B: capture mem_rdata into temp_a; mem_addr=addr_b, mem_rd=1. Next state EXEC.
- EXEC:
  - temp_a is taken from mem_rdata if READ_B was skipped.
  - temp_b is taken from mem_rdata, or from the latched imm when req_b_imm.
  - ALU is evaluated with op, carry_acc and decimal. Latch result into result_reg and ALU carry-out into carry_acc; zero_acc &= ALU zero.
  - use_carry to the ALU = req_use_carry on the first nibble, forced 1 on later nibbles.
  - Next state WRITE.
- WRITE:
  - If writeback: mem_addr=addr_a, mem_wr=1, mem_wdata=result_reg.
  - If nibbles remain: addr_a+=1, addr_b+=1 (modulo 2^ADDR_WIDTH, wrapping to 0), count-=1, go to READ_A.
  - Else go to DONE.
- DONE: done=1; flag_carry=carry_acc, flag_zero=zero_acc (registered, held until the next DONE); req_ready=0. Next state IDLE.
- Cycle counts:
  - Memory-B nibble: 4 cycles (READ_A, READ_B, EXEC, WRITE).
  - Immediate/unary nibble: 3 cycles.
  - done rises 5 cycles after the accept edge for a single memory-B nibble.
- Logic ops (AND/OR/XOR/NOT): carry passes through unchanged, as the ALU defines.
- mem_rd and mem_wr are never both high. With writeback=0, mem_wr never asserts.
- req_valid outside IDLE is ignored; request fields may change freely while busy.
- Reset mid-operation: asynchronous return to IDLE. mem_wr/mem_rd drop immediately, the partial write is abandoned, flags clear, no done pulse.

Decomposition:
- types package gains:
  - seq_state enum (IDLE, READ_A, READ_B, EXEC, WRITE, DONE)
  - predicate function is_unary(alu_op)
- Existing alu_op is reused unchanged.
- One sub-module: alu, instantiated once and fed from temp_a/temp_b registers and carry_acc.

Test Plan:
- ADD, decimal=1, mem[0x010]=7, mem[0x020]=5, len=0, writeback=1 -> mem[0x010]=2, flag_carry=1, flag_zero=0, done 5 cycles after accept.
- ADD decimal, A nibbles @0x100..0x102 = 9,9,1, B @0x200.. = 1,0,0, len=2 -> A nibbles become 0,0,2, flag_carry=0, flag_zero=0.
- CP (writeback=0), A=3, B=5 -> flag_carry=1, flag_zero=0, mem_wr never asserted.
- SUB, len=1, A=1,1, B=1,1 -> both nibbles 0, flag_zero=1, flag_carry=0.
- XOR with req_b_imm=1, imm=0xF, A=0x5, flag_carry_in=1 -> mem=0xA, flag_carry=1, done 4 cycles after accept.
- Address wrap: addr_a=0xFFF, len=1 -> second write lands at 0x000.
- Reset mid-op: reset asserted during WRITE -> mem_wr=0 the same cycle, no done, req_ready=1 after release.
